// File: rtl/median9_sort_sched.sv
// Median of a 3x3 window computed by sequencing one external registered 3-input sorter over seven passes.
// Latency: accept edge to first out_valid cycle is 8 + 3*SORT_LAT cycles.
// Backpressure: one window in flight; in_ready only in IDLE, out_median held while out_valid && !out_ready.
module median9_sort_sched #(
  parameter int SORT_LAT = 1,
  parameter int DW       = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [9*DW-1:0] in_pix,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_median,
  output logic            busy,
  output logic [DW-1:0]   srt_data1,
  output logic [DW-1:0]   srt_data2,
  output logic [DW-1:0]   srt_data3,
  input  logic [DW-1:0]   srt_max,
  input  logic [DW-1:0]   srt_mid,
  input  logic [DW-1:0]   srt_min
);

  // The tag pipeline and wait counter are only sized for sorter latencies 1..4.
  generate
    if (SORT_LAT < 1 || SORT_LAT > 4) begin : g_lat_chk
      $error("median9_sort_sched: SORT_LAT must be in the range 1..4");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROW,
    S_WAIT_ROW,
    S_COL,
    S_WAIT_COL,
    S_FIN,
    S_WAIT_FIN,
    S_OUT
  } state_t;

  // Pass identifiers carried alongside each issue so results land in the right scratch slot.
  localparam logic [2:0] ID_ROW0 = 3'd0;
  localparam logic [2:0] ID_ROW1 = 3'd1;
  localparam logic [2:0] ID_ROW2 = 3'd2;
  localparam logic [2:0] ID_A    = 3'd3;
  localparam logic [2:0] ID_B    = 3'd4;
  localparam logic [2:0] ID_C    = 3'd5;
  localparam logic [2:0] ID_FIN  = 3'd6;

  // Each wait state lasts SORT_LAT cycles; the counter runs SORT_LAT-1 down to 0.
  localparam logic [1:0] WAIT_INIT = 2'(SORT_LAT - 1);

  state_t      state, state_nxt;
  logic [1:0]  idx, idx_nxt;
  logic [1:0]  wait_cnt, wait_nxt;
  logic        rdy_en;

  logic        iss_vld;
  logic [2:0]  iss_id;
  logic        win_load;
  logic        out_load;

  // Pixels p3..p8; row 0 is issued straight from in_pix on the accept edge.
  logic [DW-1:0] win_q [0:5];

  // Scratch bank: per-row sort results and the three column extremes.
  logic [DW-1:0] rmax_q [0:2];
  logic [DW-1:0] rmid_q [0:2];
  logic [DW-1:0] rmin_q [0:2];
  logic [DW-1:0] a_q, b_q, c_q;

  // Scratch values including any result being sampled this cycle.
  logic [DW-1:0] rmax_e [0:2];
  logic [DW-1:0] rmid_e [0:2];
  logic [DW-1:0] rmin_e [0:2];
  logic [DW-1:0] a_e, b_e, c_e;

  logic [DW-1:0] op1, op2, op3;

  // Stage 0 matches the cycle the operands are on srt_data; stage SORT_LAT matches the result cycle.
  logic          tag_vld [0:SORT_LAT];
  logic [2:0]    tag_id  [0:SORT_LAT];
  logic          res_vld;
  logic [2:0]    res_id;

  assign res_vld = tag_vld[SORT_LAT];
  assign res_id  = tag_id[SORT_LAT];

  // State, pass index, wait counter and the post-reset ready enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      idx      <= 2'd0;
      wait_cnt <= 2'd0;
      rdy_en   <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      wait_cnt <= wait_nxt;
      rdy_en   <= 1'b1;
    end
  end

  // Pass sequencing: decides which pass issues on the coming edge and when to move on.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wait_nxt  = wait_cnt;
    iss_vld   = 1'b0;
    iss_id    = ID_ROW0;
    win_load  = 1'b0;
    out_load  = 1'b0;
    in_ready  = (state == S_IDLE) && rdy_en;
    busy      = (state != S_IDLE);
    out_valid = (state == S_OUT);
    case (state)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          win_load  = 1'b1;
          iss_vld   = 1'b1;
          iss_id    = ID_ROW0;
          idx_nxt   = 2'd1;
          state_nxt = S_ROW;
        end
      end
      S_ROW: begin
        if (idx == 2'd3) begin
          wait_nxt  = WAIT_INIT;
          state_nxt = S_WAIT_ROW;
        end else begin
          iss_vld = 1'b1;
          iss_id  = {1'b0, idx};
          idx_nxt = idx + 2'd1;
        end
      end
      S_WAIT_ROW: begin
        if (wait_cnt == 2'd0) begin
          iss_vld   = 1'b1;
          iss_id    = ID_A;
          idx_nxt   = 2'd1;
          state_nxt = S_COL;
        end else begin
          wait_nxt = wait_cnt - 2'd1;
        end
      end
      S_COL: begin
        if (idx == 2'd3) begin
          wait_nxt  = WAIT_INIT;
          state_nxt = S_WAIT_COL;
        end else begin
          iss_vld = 1'b1;
          iss_id  = (idx == 2'd1) ? ID_B : ID_C;
          idx_nxt = idx + 2'd1;
        end
      end
      S_WAIT_COL: begin
        if (wait_cnt == 2'd0) begin
          iss_vld   = 1'b1;
          iss_id    = ID_FIN;
          state_nxt = S_FIN;
        end else begin
          wait_nxt = wait_cnt - 2'd1;
        end
      end
      S_FIN: begin
        wait_nxt  = WAIT_INIT;
        state_nxt = S_WAIT_FIN;
      end
      S_WAIT_FIN: begin
        if (wait_cnt == 2'd0) begin
          out_load  = 1'b1;
          state_nxt = S_OUT;
        end else begin
          wait_nxt = wait_cnt - 2'd1;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Forward a result sampled this cycle so the dependent pass can issue on the same edge.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      rmax_e[r] = rmax_q[r];
      rmid_e[r] = rmid_q[r];
      rmin_e[r] = rmin_q[r];
      if (res_vld && res_id == 3'(r)) begin
        rmax_e[r] = srt_max;
        rmid_e[r] = srt_mid;
        rmin_e[r] = srt_min;
      end
    end
    a_e = a_q;
    b_e = b_q;
    c_e = c_q;
    if (res_vld && res_id == ID_A) a_e = srt_max;
    if (res_vld && res_id == ID_B) b_e = srt_mid;
    if (res_vld && res_id == ID_C) c_e = srt_min;
  end

  // Operand select for the pass issuing on the coming edge.
  always_comb begin
    op1 = '0;
    op2 = '0;
    op3 = '0;
    case (iss_id)
      ID_ROW0: begin
        op1 = in_pix[0*DW +: DW];
        op2 = in_pix[1*DW +: DW];
        op3 = in_pix[2*DW +: DW];
      end
      ID_ROW1: begin
        op1 = win_q[0];
        op2 = win_q[1];
        op3 = win_q[2];
      end
      ID_ROW2: begin
        op1 = win_q[3];
        op2 = win_q[4];
        op3 = win_q[5];
      end
      ID_A: begin
        op1 = rmin_e[0];
        op2 = rmin_e[1];
        op3 = rmin_e[2];
      end
      ID_B: begin
        op1 = rmid_e[0];
        op2 = rmid_e[1];
        op3 = rmid_e[2];
      end
      ID_C: begin
        op1 = rmax_e[0];
        op2 = rmax_e[1];
        op3 = rmax_e[2];
      end
      ID_FIN: begin
        op1 = a_e;
        op2 = b_e;
        op3 = c_e;
      end
      default: begin
        op1 = '0;
        op2 = '0;
        op3 = '0;
      end
    endcase
  end

  // Registered sorter operands; zero in every cycle that carries no pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      srt_data1 <= '0;
      srt_data2 <= '0;
      srt_data3 <= '0;
    end else if (iss_vld) begin
      srt_data1 <= op1;
      srt_data2 <= op2;
      srt_data3 <= op3;
    end else begin
      srt_data1 <= '0;
      srt_data2 <= '0;
      srt_data3 <= '0;
    end
  end

  // Tag pipeline tracking which pass each sorter result belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= SORT_LAT; k++) begin
        tag_vld[k] <= 1'b0;
        tag_id[k]  <= 3'd0;
      end
    end else begin
      tag_vld[0] <= iss_vld;
      tag_id[0]  <= iss_id;
      for (int k = 1; k <= SORT_LAT; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_id[k]  <= tag_id[k-1];
      end
    end
  end

  // Window capture of rows 1 and 2 on the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) begin
        win_q[i] <= '0;
      end
    end else if (win_load) begin
      for (int i = 0; i < 6; i++) begin
        win_q[i] <= in_pix[(i+3)*DW +: DW];
      end
    end
  end

  // Scratch bank update; the forwarded view already folds in this cycle's result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        rmax_q[r] <= '0;
        rmid_q[r] <= '0;
        rmin_q[r] <= '0;
      end
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
    end else begin
      for (int r = 0; r < 3; r++) begin
        rmax_q[r] <= rmax_e[r];
        rmid_q[r] <= rmid_e[r];
        rmin_q[r] <= rmin_e[r];
      end
      a_q <= a_e;
      b_q <= b_e;
      c_q <= c_e;
    end
  end

  // Final median capture; held until the sink takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_median <= '0;
    end else if (out_load) begin
      out_median <= srt_mid;
    end
  end

endmodule

// File: tb/tb_median9_sort_sched.sv
// Directed bench for median9_sort_sched: one instance with a 1-cycle sorter, one with a 3-stage sorter.
// Expected medians, operand sequences and latencies are hand-computed constants.
// Inputs driven and outputs sampled on the falling edge.
module tb_median9_sort_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [71:0] a_in_pix;
  logic [7:0]  a_out_median, a_sd1, a_sd2, a_sd3, a_smax, a_smid, a_smin;
  logic [23:0] a_ops;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [71:0] b_in_pix;
  logic [7:0]  b_out_median, b_sd1, b_sd2, b_sd3, b_smax, b_smid, b_smin;

  int n_checks = 0;
  int n_errors = 0;

  median9_sort_sched #(.SORT_LAT(1), .DW(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_pix(a_in_pix),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_median(a_out_median),
    .busy(a_busy),
    .srt_data1(a_sd1), .srt_data2(a_sd2), .srt_data3(a_sd3),
    .srt_max(a_smax), .srt_mid(a_smid), .srt_min(a_smin)
  );

  median9_sort_sched #(.SORT_LAT(3), .DW(8)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_pix(b_in_pix),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_median(b_out_median),
    .busy(b_busy),
    .srt_data1(b_sd1), .srt_data2(b_sd2), .srt_data3(b_sd3),
    .srt_max(b_smax), .srt_mid(b_smid), .srt_min(b_smin)
  );

  assign a_ops = {a_sd1, a_sd2, a_sd3};

  function automatic logic [23:0] sort3(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
    logic [7:0] hi, lo, md;
    logic [9:0] sum;
    hi  = (x > y) ? x : y;
    hi  = (hi > z) ? hi : z;
    lo  = (x < y) ? x : y;
    lo  = (lo < z) ? lo : z;
    sum = 10'(x) + 10'(y) + 10'(z) - 10'(hi) - 10'(lo);
    md  = sum[7:0];
    return {hi, md, lo};
  endfunction

  function automatic logic [71:0] win9(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                                       input logic [7:0] p3, input logic [7:0] p4, input logic [7:0] p5,
                                       input logic [7:0] p6, input logic [7:0] p7, input logic [7:0] p8);
    return {p8, p7, p6, p5, p4, p3, p2, p1, p0};
  endfunction

  // Sorter models: registered, latency 1 for instance a, 3 for instance b.
  logic [23:0] a_sres = 24'd0;
  logic [23:0] b_pipe [0:2];
  initial for (int i = 0; i < 3; i++) b_pipe[i] = 24'd0;

  always @(posedge clk) a_sres <= sort3(a_sd1, a_sd2, a_sd3);
  always @(posedge clk) begin
    b_pipe[0] <= sort3(b_sd1, b_sd2, b_sd3);
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign {a_smax, a_smid, a_smin} = a_sres;
  assign {b_smax, b_smid, b_smin} = b_pipe[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Present a window on instance a and return at the falling edge of c1.
  task automatic a_send(input logic [71:0] pix);
    int n;
    n = 0;
    a_in_pix   = pix;
    a_in_valid = 1'b1;
    while (a_in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (a_in_ready !== 1'b1) check("a_send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
  endtask

  // Called at c1; returns the cycle number in which out_valid is first seen, -1 on timeout.
  task automatic a_wait(output int cyc);
    cyc = 1;
    while (a_out_valid !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (a_out_valid !== 1'b1) cyc = -1;
  endtask

  task automatic a_run(input logic [71:0] pix, input logic [7:0] exp_med, input string tag);
    int lat;
    a_send(pix);
    a_wait(lat);
    check({tag, "_lat"}, lat, 32'd11);
    check({tag, "_med"}, a_out_median, exp_med);
    @(negedge clk);
    check({tag, "_idle"}, {a_out_valid, a_in_ready}, 2'b01);
  endtask

  logic [23:0] exp1 [1:11];
  logic [71:0] wins [0:3];
  logic [7:0]  exp4 [0:3];
  logic [7:0]  meds [0:3];
  int          acc_t [0:3];
  int          lat, nacc, nmed, spur;
  logic [95:0] rnd;

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_pix = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_pix = '0; b_out_ready = 1'b1;

    // Reset values
    #1;
    check("rst_in_ready", a_in_ready, 1'b0);
    check("rst_out_valid", a_out_valid, 1'b0);
    check("rst_busy", a_busy, 1'b0);
    check("rst_median", a_out_median, 8'd0);
    check("rst_ops", a_ops, 24'd0);
    check("rst_b_in_ready", b_in_ready, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", a_in_ready, 1'b1);
    check("rel_b_in_ready", b_in_ready, 1'b1);

    // Test 1: operand schedule and latency, L=1
    exp1[1]  = {8'd10, 8'd200, 8'd30};
    exp1[2]  = {8'd40, 8'd50, 8'd60};
    exp1[3]  = {8'd255, 8'd0, 8'd128};
    exp1[4]  = 24'd0;
    exp1[5]  = {8'd10, 8'd40, 8'd0};
    exp1[6]  = {8'd30, 8'd50, 8'd128};
    exp1[7]  = {8'd200, 8'd60, 8'd255};
    exp1[8]  = 24'd0;
    exp1[9]  = {8'd40, 8'd50, 8'd60};
    exp1[10] = 24'd0;
    exp1[11] = 24'd0;
    a_send(win9(10, 200, 30, 40, 50, 60, 255, 0, 128));
    check("t1_busy", a_busy, 1'b1);
    for (int c = 1; c <= 11; c++) begin
      check($sformatf("t1_ops_c%0d", c), a_ops, exp1[c]);
      check($sformatf("t1_vld_c%0d", c), a_out_valid, (c == 11) ? 32'd1 : 32'd0);
      if (c < 11) @(negedge clk);
    end
    check("t1_med", a_out_median, 8'd50);
    check("t1_in_ready_hs", a_in_ready, 1'b0);
    @(negedge clk);
    check("t1_idle", {a_out_valid, a_in_ready}, 2'b01);

    // Test 2: uniform windows
    a_run(win9(8'h7f, 8'h7f, 8'h7f, 8'h7f, 8'h7f, 8'h7f, 8'h7f, 8'h7f, 8'h7f), 8'h7f, "t2_7f");
    a_run(win9(0, 0, 0, 0, 0, 0, 0, 0, 0), 8'h00, "t2_00");
    a_run(win9(8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff), 8'hff, "t2_ff");

    // Test 3: output backpressure for five cycles, handshake on the sixth
    a_out_ready = 1'b0;
    a_send(win9(0, 255, 128, 64, 192, 32, 16, 240, 8));
    a_wait(lat);
    check("t3_lat", lat, 32'd11);
    for (int k = 1; k <= 6; k++) begin
      check($sformatf("t3_vld_%0d", k), a_out_valid, 1'b1);
      check($sformatf("t3_med_%0d", k), a_out_median, 8'd64);
      check($sformatf("t3_rdy_%0d", k), a_in_ready, 1'b0);
      check($sformatf("t3_busy_%0d", k), a_busy, 1'b1);
      if (k == 6) a_out_ready = 1'b1;
      @(negedge clk);
    end
    check("t3_after", {a_out_valid, a_in_ready, a_busy}, 3'b010);

    // Test 4: back-to-back windows, in_pix scrambled while busy
    wins[0] = win9(1, 2, 3, 4, 5, 6, 7, 8, 9);
    wins[1] = win9(100, 3, 77, 20, 250, 20, 6, 6, 200);
    wins[2] = win9(0, 255, 128, 64, 192, 32, 16, 240, 8);
    wins[3] = win9(7, 7, 7, 7, 3, 7, 7, 7, 7);
    exp4[0] = 8'd5; exp4[1] = 8'd20; exp4[2] = 8'd64; exp4[3] = 8'd7;
    for (int k = 0; k < 4; k++) begin meds[k] = 8'd0; acc_t[k] = 0; end
    nacc = 0; nmed = 0;
    a_in_valid = 1'b1;
    a_in_pix   = wins[0];
    for (int t = 0; t < 400 && nmed < 4; t++) begin
      if (a_out_valid === 1'b1) begin
        if (nmed < 4) meds[nmed] = a_out_median;
        nmed++;
      end
      if (a_in_ready === 1'b1) begin
        if (nacc < 4) begin
          a_in_pix = wins[nacc];
          acc_t[nacc] = t;
          nacc++;
        end else begin
          a_in_valid = 1'b0;
        end
      end else begin
        rnd = {$urandom(), $urandom(), $urandom()};
        a_in_pix = rnd[71:0];
      end
      @(negedge clk);
    end
    a_in_valid = 1'b0;
    spur = 0;
    repeat (15) begin
      if (a_out_valid !== 1'b0) spur++;
      @(negedge clk);
    end
    check("t4_count", nmed, 32'd4);
    check("t4_extra", spur, 32'd0);
    for (int k = 0; k < 4; k++) check($sformatf("t4_med_%0d", k), meds[k], exp4[k]);
    for (int k = 1; k < 4; k++) check($sformatf("t4_gap_%0d", k), acc_t[k] - acc_t[k-1], 32'd12);

    // Test 5: reset asserted during c5
    a_send(win9(10, 200, 30, 40, 50, 60, 255, 0, 128));
    repeat (4) @(negedge clk);
    check("t5_ops_c5", a_ops, {8'd10, 8'd40, 8'd0});
    rst_n = 1'b0;
    #1;
    check("t5_rst_ops", a_ops, 24'd0);
    check("t5_rst_busy", a_busy, 1'b0);
    check("t5_rst_vld", a_out_valid, 1'b0);
    check("t5_rst_rdy", a_in_ready, 1'b0);
    check("t5_rst_med", a_out_median, 8'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_rel_rdy", a_in_ready, 1'b1);
    spur = 0;
    repeat (12) begin
      if (a_out_valid !== 1'b0) spur++;
      @(negedge clk);
    end
    check("t5_spurious", spur, 32'd0);
    a_run(wins[3], 8'd7, "t5_next");

    // Test 6: SORT_LAT=3 instance
    b_in_pix   = win9(9, 8, 7, 6, 5, 4, 3, 2, 1);
    b_in_valid = 1'b1;
    lat = 0;
    while (b_in_ready !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (b_in_ready !== 1'b1) check("t6_send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    b_in_valid = 1'b0;
    check("t6_busy", b_busy, 1'b1);
    lat = 1;
    while (b_out_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (b_out_valid !== 1'b1) lat = -1;
    check("t6_lat", lat, 32'd17);
    check("t6_med", b_out_median, 8'd5);
    @(negedge clk);
    check("t6_idle", {b_out_valid, b_in_ready}, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/median9_sort_sched.md
Name: median9_sort_sched

Overview:
- Computes the median of a 3x3 pixel window by time-multiplexing a single external registered 3-input sorter over seven passes.
- Pass order: three row sorts, then three column-extreme sorts, then one final sort.
- Sits between the window builder (valid/ready source) and the downstream pixel sink (valid/ready sink) in the image-filter path.
- Sequences sorter operands and captures sorter results in an internal scratch bank.

Parameters:
SORT_LAT, 1, sorter latency in cycles from the operand cycle to the result-valid cycle; legal range 1..4.
DW, 8, pixel width in bits.

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
in_valid  in  1  window valid
in_ready  out  1  window accepted when in_valid && in_ready at a rising edge
in_pix  in  9*DW  window, row-major; p0 at [DW-1:0], p8 at MSB
out_valid  out  1  median valid
out_ready  in  1  sink ready
out_median  out  DW  median result
busy  out  1  high in every state except IDLE
srt_data1  out  DW  sorter operand 1 (registered)
srt_data2  out  DW  sorter operand 2 (registered)
srt_data3  out  DW  sorter operand 3 (registered)
srt_max  in  DW  sorter max result
srt_mid  in  DW  sorter mid result
srt_min  in  DW  sorter min result

Behaviour:
- Reset values: in_ready=0 during reset and 1 from the first cycle after release; out_valid=0; out_median=0; busy=0; srt_data1..3=0; FSM=IDLE; scratch registers=0.
- Accept: window latched at edge E0 when in_valid && in_ready. in_ready=1 only in IDLE. in_pix is ignored at all other times.
- Cycle numbering: c1 is the cycle after E0.
- Result timing: the result of a pass issued in cycle c is sampled at the end of cycle c+SORT_LAT.
- srt_data1..3 are 0 in every non-issue cycle.
- FSM states: IDLE, ROW, WAIT_ROW, COL, WAIT_COL, FIN, WAIT_FIN, OUT.
- ROW, cycles c1..c3: issue row r=0,1,2 as (p3r, p3r+1, p3r+2). Store maxr, midr, minr.
- WAIT_ROW: hold until the row-2 result is sampled (end of c3+L), using an internal wait counter.
- COL, cycles c4+L..c6+L:
  - pass A = (min0,min1,min2), keep max -> a.
  - pass B = (mid0,mid1,mid2), keep mid -> b.
  - pass C = (max0,max1,max2), keep min -> c.
- WAIT_COL: hold until the pass-C result is sampled (end of c6+2L).
- FIN, cycle c7+2L: issue (a,b,c), keep mid.
- WAIT_FIN: hold until sampled (end of c7+3L); result loaded into out_median.
- OUT: out_valid=1 from cycle c8+3L.
  - out_median holds stable while out_valid && !out_ready.
  - On the out_valid && out_ready edge: out_valid=0, return to IDLE.
- Latency: accept edge to first out_valid cycle = 8+3*SORT_LAT cycles (11 for L=1).
- Minimum accept period: 9+3*SORT_LAT cycles (12 for L=1), with out_ready held high.
- No new window is accepted in the same cycle as the output handshake; in_ready rises in the following cycle.
- Ties: equal values are legal; the result is numerically the median regardless of which duplicate the sorter routes.
- Unsigned compare only; no arithmetic and no width growth.
- Reset mid-operation: all state returns to reset values immediately; the in-flight window is discarded. Sorter results arriving after reset release are ignored because the FSM is in IDLE.
- SORT_LAT outside 1..4: elaboration-time error.

Test Plan:
1. L=1, window (10,200,30, 40,50,60, 255,0,128) -> out_median=50 exactly 11 cycles after accept. srt_data sequence:
   - ROW: (10,200,30),(40,50,60),(255,0,128).
   - COL: (10,40,0),(30,50,128),(200,60,255).
   - FIN: (40,50,60).
2. All nine pixels 0x7F -> out_median=0x7F. All 0x00 and all 0xFF windows -> 0x00 and 0xFF respectively.
3. Backpressure: out_ready=0 for 5 cycles after out_valid rises -> out_valid and out_median stable, in_ready=0, busy=1. Handshake on the 6th cycle, then in_ready=1 the next cycle.
4. Back-to-back: in_valid=1, out_ready=1 continuously, 4 distinct windows -> accepts exactly 12 cycles apart; medians in order, none dropped or duplicated. in_pix changed during processing has no effect.
5. Reset mid-operation: assert rst_n=0 in cycle c5 -> outputs at reset values asynchronously. After release: in_ready=1, no spurious out_valid. Next window yields its correct median.
6. SORT_LAT=3 with a 3-stage sorter model, window (9,8,7,6,5,4,3,2,1) -> out_median=5 exactly 17 cycles after accept.
